// File: rtl/jt12_acc_mix_if.sv
// Operator-stage stream in, channel and stereo samples out.
// master drives the slot stream (operator stage / bench), slave is the mixer.
interface jt12_acc_mix_if;
    logic               clk_en;
    logic               zero;
    logic signed [13:0] op_result;
    logic [2:0]         alg;
    logic [1:0]         pan;
    logic signed [13:0] ch_out;
    logic [2:0]         ch_voice;
    logic               ch_valid;
    logic signed [15:0] snd_left;
    logic signed [15:0] snd_right;
    logic               snd_sample;

    modport master (
        output clk_en, zero, op_result, alg, pan,
        input  ch_out, ch_voice, ch_valid, snd_left, snd_right, snd_sample
    );

    modport slave (
        input  clk_en, zero, op_result, alg, pan,
        output ch_out, ch_voice, ch_valid, snd_left, snd_right, snd_sample
    );
endinterface

// File: rtl/jt12_acc_mix.sv
// Channel accumulator and stereo mixer for the 24-slot operator stream:
// sums carriers per voice, saturates to 14 bits, pans and mixes to 16-bit L/R.
module jt12_acc_mix #(
    parameter int NUM_VOICES = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    jt12_acc_mix_if.slave  bus
);
    localparam logic [4:0] LAST_SLOT = 5'(4*NUM_VOICES - 1);
    localparam logic [1:0] GRP_S1 = 2'd0;
    localparam logic [1:0] GRP_S3 = 2'd1;
    localparam logic [1:0] GRP_S2 = 2'd2;
    localparam logic [1:0] GRP_S4 = 2'd3;

    function automatic logic signed [13:0] sat14(input logic signed [15:0] x);
        if (x > 16'sd8191)       return 14'sd8191;
        else if (x < -16'sd8192) return -14'sd8192;
        else                     return 14'(x);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        if (x > 18'sd32767)       return 16'sd32767;
        else if (x < -18'sd32768) return -16'sd32768;
        else                      return 16'(x);
    endfunction

    logic [4:0]         cnt_q, cnt_d, slot;
    logic [1:0]         grp;
    logic [2:0]         voice;
    logic               carrier, is_last;

    logic signed [15:0] sr_q [NUM_VOICES];
    logic signed [15:0] cur, op16, contrib, final_sum, entry_d;
    logic signed [13:0] chan;

    logic signed [17:0] acc_l_q, acc_r_q, acc_l_d, acc_r_d;
    logic signed [17:0] chan18, add_l, add_r, sum_l, sum_r;

    logic signed [13:0] ch_out_q;
    logic [2:0]         ch_voice_q;
    logic               ch_vld_q;
    logic signed [15:0] snd_l_q, snd_r_q;
    logic               snd_vld_q;

    // Slot decode: a zero strobe always wins so the frame can be resynced.
    always_comb begin
        slot    = bus.zero ? 5'd0 : cnt_q;
        is_last = (slot == LAST_SLOT);
        cnt_d   = is_last ? 5'd0 : slot + 5'd1;
        if (slot >= 5'd18) begin
            grp   = GRP_S4;
            voice = 3'(slot - 5'd18);
        end else if (slot >= 5'd12) begin
            grp   = GRP_S2;
            voice = 3'(slot - 5'd12);
        end else if (slot >= 5'd6) begin
            grp   = GRP_S3;
            voice = 3'(slot - 5'd6);
        end else begin
            grp   = GRP_S1;
            voice = 3'(slot);
        end
    end

    always_comb begin
        carrier = 1'b1;
        case (grp)
            GRP_S1:  carrier = (bus.alg == 3'd7);
            GRP_S3:  carrier = (bus.alg >= 3'd5);
            GRP_S2:  carrier = (bus.alg >= 3'd4);
            default: carrier = 1'b1;
        endcase
    end

    // The oldest shift-register entry always belongs to the current voice,
    // since each voice comes round again exactly NUM_VOICES slots later.
    always_comb begin
        cur       = sr_q[NUM_VOICES-1];
        op16      = 16'(bus.op_result);
        contrib   = carrier ? op16 : 16'sd0;
        final_sum = cur + op16;
        chan      = sat14(final_sum);
        entry_d   = 16'sd0;
        case (grp)
            GRP_S1:  entry_d = contrib;
            GRP_S3,
            GRP_S2:  entry_d = cur + contrib;
            default: entry_d = 16'sd0;
        endcase
    end

    always_comb begin
        chan18  = 18'(chan);
        add_l   = bus.pan[1] ? chan18 : 18'sd0;
        add_r   = bus.pan[0] ? chan18 : 18'sd0;
        sum_l   = acc_l_q + add_l;
        sum_r   = acc_r_q + add_r;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (grp == GRP_S4) begin
            // voice 0 opens the mix so no stale frame data survives
            acc_l_d = (voice == 3'd0) ? add_l : sum_l;
            acc_r_d = (voice == 3'd0) ? add_r : sum_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) sr_q[i] <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            ch_out_q   <= '0;
            ch_voice_q <= '0;
            ch_vld_q   <= 1'b0;
            snd_l_q    <= '0;
            snd_r_q    <= '0;
            snd_vld_q  <= 1'b0;
        end else if (bus.clk_en) begin
            cnt_q   <= cnt_d;
            sr_q[0] <= entry_d;
            for (int i = 1; i < NUM_VOICES; i++) sr_q[i] <= sr_q[i-1];
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            if (grp == GRP_S4) begin
                ch_out_q   <= chan;
                ch_voice_q <= voice;
            end
            ch_vld_q <= (grp == GRP_S4);
            if (is_last) begin
                snd_l_q <= sat16(sum_l);
                snd_r_q <= sat16(sum_r);
            end
            snd_vld_q <= is_last;
        end
    end

    // Strobe flops hold across disabled cycles; gating by clk_en lets each
    // strobe land on exactly one enabled cycle.
    assign bus.ch_out     = ch_out_q;
    assign bus.ch_voice   = ch_voice_q;
    assign bus.ch_valid   = ch_vld_q & bus.clk_en;
    assign bus.snd_left   = snd_l_q;
    assign bus.snd_right  = snd_r_q;
    assign bus.snd_sample = snd_vld_q & bus.clk_en;
endmodule
